// File: rtl/q3_bit_serializer.sv
// q3_bit_serializer
//   Parallel-to-serial feeder for the divisible-by-5 serial checker. A word is
//   taken on a valid/ready handshake and sent MSB-first, one bit per clock, with
//   framing strobes so the consumer can realign its remainder FSM per word.
//
// Parameters
//   WIDTH  bits per word (>= 2)
//   GAP    idle cycles inserted after each word's last bit (>= 0)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_data holds a word to load
//   in_ready   block can accept a word this cycle
//   in_data    parallel word, bit WIDTH-1 goes out first
//   num        serial bit
//   num_valid  num carries a word bit this cycle
//   num_first  num is bit WIDTH-1 of a word
//   num_last   num is bit 0 of a word
//   busy       state is not IDLE
//   exp_d5     (Q3_SERIALIZER_REF_MOD5_EN only) golden "word mod 5 == 0"
//   exp_valid  (Q3_SERIALIZER_REF_MOD5_EN only) one-cycle pulse after num_last
//
// Optional feature macro: Q3_SERIALIZER_REF_MOD5_EN adds a reference remainder
// tracker and the exp_d5 / exp_valid ports.
module q3_bit_serializer #(
  parameter int WIDTH = 8,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             num,
  output logic             num_valid,
  output logic             num_first,
  output logic             num_last,
  output logic             busy
`ifdef Q3_SERIALIZER_REF_MOD5_EN
  ,
  output logic             exp_d5,
  output logic             exp_valid
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  // Only meaningful when GAP > 0; clamped so the GAP == 0 build stays in range.
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? (GAP - 1) : 0);
  localparam bit NO_GAP = (GAP == 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;

  logic is_shift;
  logic is_last;
  logic hs;

  assign is_shift = (state_q == S_SHIFT);
  assign is_last  = is_shift && (cnt_q == LAST_CNT);

  // With no gap the last-bit cycle also accepts the next word so words stream
  // back to back without a bubble.
  assign in_ready = (state_q == S_IDLE) || (is_last && NO_GAP);
  assign hs       = in_valid && in_ready;

  // Outputs come straight from state and shift-register flops only.
  assign num_valid = is_shift;
  assign num       = is_shift && sreg_q[WIDTH-1];
  assign num_first = is_shift && (cnt_q == '0);
  assign num_last  = is_last;
  assign busy      = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    case (state_q)
      S_IDLE: begin
        if (hs) begin
          sreg_d  = in_data;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
        cnt_d  = cnt_q + CW'(1);
        if (is_last) begin
          cnt_d = '0;
          if (hs) begin
            sreg_d  = in_data;
            state_d = S_SHIFT;
          end else if (NO_GAP) begin
            state_d = S_IDLE;
          end else begin
            gcnt_d  = GAP_LOAD;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        // Loaded with GAP-1 and left on the cycle it reads 0: GAP cycles total.
        if (gcnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gcnt_d = gcnt_q - GW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef Q3_SERIALIZER_REF_MOD5_EN
  // Reference remainder of the bits sent so far, kept in 0..4.
  logic [2:0] rem_q;
  logic [3:0] rem_dbl;
  logic [2:0] rem_nxt;

  assign rem_dbl = {rem_q, 1'b0} + {3'b000, num};
  assign rem_nxt = (rem_dbl >= 4'd5) ? 3'(rem_dbl - 4'd5) : rem_dbl[2:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q     <= '0;
      exp_d5    <= 1'b0;
      exp_valid <= 1'b0;
    end else begin
      // A handshake in the last-bit cycle clears for the next word; the
      // finishing word's result is taken from rem_nxt below.
      if (hs) begin
        rem_q <= '0;
      end else if (num_valid) begin
        rem_q <= rem_nxt;
      end
      exp_valid <= is_last;
      if (is_last) begin
        exp_d5 <= (rem_nxt == 3'd0);
      end
    end
  end
`endif

endmodule

// File: tb/tb_q3_bit_serializer.sv
// Directed bench for q3_bit_serializer: u0 is built with GAP=0, u2 with GAP=2.
module tb_q3_bit_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       v0 = 1'b0, v2 = 1'b0;
  logic [7:0] d0 = '0, d2 = '0;
  logic       rdy0, num0, nv0, nf0, nl0, bsy0;
  logic       rdy2, num2, nv2, nf2, nl2, bsy2;
`ifdef Q3_SERIALIZER_REF_MOD5_EN
  logic       ed0, ev0, ed2, ev2;
`endif

  int total = 0;
  int bad   = 0;

  q3_bit_serializer #(.WIDTH(8), .GAP(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(rdy0), .in_data(d0),
    .num(num0), .num_valid(nv0), .num_first(nf0), .num_last(nl0), .busy(bsy0)
`ifdef Q3_SERIALIZER_REF_MOD5_EN
    , .exp_d5(ed0), .exp_valid(ev0)
`endif
  );

  q3_bit_serializer #(.WIDTH(8), .GAP(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2), .in_data(d2),
    .num(num2), .num_valid(nv2), .num_first(nf2), .num_last(nl2), .busy(bsy2)
`ifdef Q3_SERIALIZER_REF_MOD5_EN
    , .exp_d5(ed2), .exp_valid(ev2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load one word on u0 and check its 8 bit cycles against a hand-written
  // pattern; returns positioned in the cycle after num_last.
  task automatic send0(input logic [7:0] w, input logic [7:0] pat, input string tag);
    v0 = 1'b1;
    d0 = w;
    step();
    v0 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk({tag, "_num"},   num0, pat[7-k]);
      chk({tag, "_vld"},   nv0,  1'b1);
      chk({tag, "_first"}, nf0,  k == 0);
      chk({tag, "_last"},  nl0,  k == 7);
      chk({tag, "_rdy"},   rdy0, k == 7);
      step();
    end
  endtask

  initial begin
    logic [15:0] b2b;
    logic [7:0]  p81;
    b2b = 16'b0000111111110000;
    p81 = 8'b10000001;

    // Reset: held 3 cycles, in_ready reads 1 throughout.
    repeat (3) step();
    chk("rst_rdy_in", rdy0, 1'b1);
    chk("rst_nv_in",  nv0,  1'b0);
    rst_n = 1'b1;
    step();
    chk("rst_num",   num0, 1'b0);
    chk("rst_nv",    nv0,  1'b0);
    chk("rst_first", nf0,  1'b0);
    chk("rst_last",  nl0,  1'b0);
    chk("rst_busy",  bsy0, 1'b0);
    chk("rst_rdy",   rdy0, 1'b1);
    chk("rst_rdy2",  rdy2, 1'b1);

    // Single word 0xA5.
    send0(8'hA5, 8'b10100101, "a5");
    chk("a5_idle_nv",   nv0,  1'b0);
    chk("a5_idle_busy", bsy0, 1'b0);
    chk("a5_idle_rdy",  rdy0, 1'b1);
    chk("a5_idle_num",  num0, 1'b0);

    // Back-to-back 0x0F then 0xF0 with in_valid held.
    v0 = 1'b1;
    d0 = 8'h0F;
    step();
    d0 = 8'hF0;
    for (int i = 0; i < 16; i++) begin
      chk("b2b_num",   num0, b2b[15-i]);
      chk("b2b_vld",   nv0,  1'b1);
      chk("b2b_first", nf0,  (i == 0) || (i == 8));
      chk("b2b_last",  nl0,  (i == 7) || (i == 15));
      chk("b2b_rdy",   rdy0, (i == 7) || (i == 15));
      if (i == 8) v0 = 1'b0;
      step();
    end
    chk("b2b_end_nv", nv0, 1'b0);
    chk("b2b_end_busy", bsy0, 1'b0);

    // GAP=2 with 0x81; a second word is offered from the last-bit cycle on.
    v2 = 1'b1;
    d2 = 8'h81;
    chk("g_rdy_pre", rdy2, 1'b1);
    step();
    v2 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("g_num",  num2, p81[7-k]);
      chk("g_vld",  nv2,  1'b1);
      chk("g_last", nl2,  k == 7);
      chk("g_rdy",  rdy2, 1'b0);
      if (k == 7) begin
        v2 = 1'b1;
        d2 = 8'h3C;
      end
      step();
    end
    for (int g = 0; g < 2; g++) begin
      chk("gap_nv",   nv2,  1'b0);
      chk("gap_rdy",  rdy2, 1'b0);
      chk("gap_busy", bsy2, 1'b1);
      chk("gap_num",  num2, 1'b0);
      step();
    end
    chk("gap_end_rdy",  rdy2, 1'b1);
    chk("gap_end_busy", bsy2, 1'b0);
    chk("gap_end_nv",   nv2,  1'b0);
    step();
    v2 = 1'b0;
    chk("g2_first", nf2,  1'b1);
    chk("g2_num",   num2, 1'b0);
    step();
    step();
    chk("g2_bit2",  num2, 1'b1);
    repeat (10) step();
    chk("g2_idle",  bsy2, 1'b0);

    // Reset during bit 4 of 0xFF.
    v0 = 1'b1;
    d0 = 8'hFF;
    step();
    v0 = 1'b0;
    repeat (4) step();
    chk("mid_nv_pre", nv0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_nv_drop",  nv0,  1'b0);
    chk("mid_num_drop", num0, 1'b0);
    chk("mid_rdy_rst",  rdy0, 1'b1);
    step();
    step();
    #2 rst_n = 1'b1;
    step();
    chk("mid_rdy",  rdy0, 1'b1);
    chk("mid_busy", bsy0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      chk("mid_resid", {30'd0, nv0, num0}, 32'd0);
      step();
    end

`ifdef Q3_SERIALIZER_REF_MOD5_EN
    // 10 -> div, 7 -> not, 0 -> div, 255 -> div.
    chk("m5_rst_ev", ev0, 1'b0);
    send0(8'd10, 8'b00001010, "m10");
    chk("m10_ev", ev0, 1'b1);
    chk("m10_d5", ed0, 1'b1);
    step();
    chk("m10_ev_off", ev0, 1'b0);
    chk("m10_hold",   ed0, 1'b1);
    send0(8'd7, 8'b00000111, "m7");
    chk("m7_ev", ev0, 1'b1);
    chk("m7_d5", ed0, 1'b0);
    send0(8'd0, 8'b00000000, "m0");
    chk("m0_ev", ev0, 1'b1);
    chk("m0_d5", ed0, 1'b1);
    send0(8'd255, 8'b11111111, "m255");
    chk("m255_ev", ev0, 1'b1);
    chk("m255_d5", ed0, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/q3_bit_serializer.md
Name: q3_bit_serializer

Overview:
- Upstream feeder for the divisible-by-5 serial checker.
- Accepts a parallel word through a valid/ready handshake and shifts it out MSB-first, one bit per clock, on `num`.
- Framing strobes (`num_first`, `num_last`) let the consumer align its remainder state machine to word boundaries.
- Optional compiled-in reference remainder gives the bench a golden divisible-by-5 flag per word.

Parameters:
- WIDTH, 8, bits per word; legal range WIDTH >= 2.
- GAP, 0, idle cycles inserted after each word's last bit; legal range GAP >= 0.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data holds a word to load
- in_ready  output  1  block can accept a word this cycle
- in_data  input  WIDTH  parallel word, bit WIDTH-1 sent first
- num  output  1  serial bit to downstream checker
- num_valid  output  1  num carries a word bit this cycle
- num_first  output  1  num is bit WIDTH-1 of a word
- num_last  output  1  num is bit 0 of a word
- busy  output  1  state is not IDLE

Behaviour:
- Reset:
  - Async clear to state IDLE; shift register, bit counter and gap counter cleared.
  - num, num_valid, num_first and num_last are 0; busy is 0.
  - in_ready reads 1 while in reset, but no capture occurs while rst_n is low.
- States:
  - IDLE: in_ready=1, num_valid=0. Handshake at edge T (in_valid & in_ready) loads in_data into the shift register and the bit counter with 0, then goes to SHIFT.
  - SHIFT: cycles T+1..T+WIDTH.
    - num = word bit WIDTH-1-k in shift cycle k.
    - num_valid=1; num_first=1 when k=0; num_last=1 when k=WIDTH-1.
    - Shift left one bit per clock.
  - After the last bit:
    - GAP=0: go to IDLE.
    - GAP>0: go to GAP with the gap counter loaded to GAP-1.
    - Exception: a handshake in the last-bit cycle reloads the shift register and stays in SHIFT.
  - GAP: num_valid=0, in_ready=0. Counter decrements each cycle; leaves to IDLE on the cycle it reads 0. Exactly GAP cycles spent here.
- in_ready = (state==IDLE) | (state==SHIFT & k==WIDTH-1 & GAP==0).
  - With GAP=0 and in_valid held, words stream with no bubble: num_first directly follows num_last.
- All num* outputs are registered state/shift-register values with no combinational path from inputs.
- Whenever num_valid=0, num, num_first and num_last are 0.
- busy = (state != IDLE).
- in_data is sampled only at the handshake edge; later changes do not affect the word in flight.
- in_valid is ignored whenever in_ready=0; no buffering, so the producer must hold the word.
- Reset asserted mid-word: outputs drop immediately and the partial word is discarded. After release the block is in IDLE with in_ready=1.
- Counter widths: bit counter $clog2(WIDTH); gap counter $clog2(GAP+1), minimum 1 bit. No wrap beyond WIDTH-1.

Optional Feature:
- Macro: Q3_SERIALIZER_REF_MOD5_EN.
- Defined:
  - Adds output ports exp_d5 (1) and exp_valid (1), plus a 3-bit remainder register.
  - Remainder is cleared on each handshake; on each valid bit it updates to rem=(2*rem+num) mod 5, with values kept in 0..4.
  - exp_valid pulses for 1 cycle in the cycle after num_last.
  - exp_d5=1 iff the final remainder is 0, held until the next pulse.
  - Both outputs reset to 0.
  - A back-to-back word's first bit coincides with the previous word's exp_valid pulse.
- Undefined: neither port nor the remainder logic exists; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release -> num=num_valid=num_first=num_last=busy=0 and in_ready=1.
- Single word, WIDTH=8, GAP=0: load 0xA5 at edge T -> num=1,0,1,0,0,1,0,1 on T+1..T+8 with num_valid=1, num_first only at T+1, num_last only at T+8, in_ready=0 on T+1..T+7 and 1 on T+8; IDLE at T+9.
- Back-to-back: in_valid held with 0x0F then 0xF0 -> 16 contiguous valid cycles, bits 0000111111110000, in_ready=1 only in cycle 8 of each word, num_first in cycle 9.
- GAP=2: load 0x81 -> after num_last, 2 cycles with num_valid=0, in_ready=0, busy=1; in_ready=1 on the third cycle; a word offered during the gap is not accepted until then.
- Reset mid-word: assert rst_n=0 during bit 4 of 0xFF -> num_valid drops immediately; after release in_ready=1, busy=0, and no residual bits appear.
- With Q3_SERIALIZER_REF_MOD5_EN: words 10, 7, 0, 255 -> exp_valid pulses after each num_last with exp_d5=1, 0, 1, 1 respectively.
